// File: rtl/gpu_line_pkg.sv
// Shared types and constants for the line-setup block: FSM state encoding,
// default coordinate width and the +1/-1 ystep values.
package gpu_line_pkg;
   localparam int LINE_WIDTH = 10;
   localparam int YSTEP_POS  = 1;
   localparam int YSTEP_NEG  = -1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STEEP, S_ORDER, S_CALC, S_START, S_RUN, S_DONE
   } line_state_e;
endpackage

// File: rtl/line_setup_x_counter.sv
// x_counter: walks xcount from the ordered start x to the end x, one step per
// en pulse while running; last_count flags the final coordinate.
import gpu_line_pkg::*;

module x_counter #(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             run,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] x_end,
   output logic [WIDTH-1:0] xcount,
   output logic             last_count
);
   logic [WIDTH-1:0] xcount_q, xcount_d;

   assign last_count = run && (xcount_q == x_end);
   assign xcount     = xcount_q;

   always_comb begin
      xcount_d = xcount_q;
      if (load)
         xcount_d = load_val;
      else if (run && en && !last_count)
         xcount_d = xcount_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) xcount_q <= '0;
      else     xcount_q <= xcount_d;
   end
endmodule

// File: rtl/line_setup.sv
// Bresenham line setup: latches endpoints, optionally swaps axes for steep lines
// (LINE_SETUP_STEEP_EN), orders by x, computes deltas/ystep and steps xcount.
import gpu_line_pkg::*;

module line_setup #(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x0_in,
   input  logic [WIDTH-1:0] y0_in,
   input  logic [WIDTH-1:0] x1_in,
   input  logic [WIDTH-1:0] y1_in,
   input  logic             req,
   input  logic             en_counter,
   output logic [WIDTH-1:0] x0,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] deltax,
   output logic [WIDTH-1:0] deltay,
   output logic [WIDTH-1:0] ystep,
   output logic [WIDTH-1:0] xcount,
   output logic             start_err,
   output logic             last_count,
   output logic             steep,
   output logic             busy,
   output logic             done
);
   typedef logic signed [WIDTH-1:0] crd_t;

   line_state_e state_q, state_d;
   crd_t        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   crd_t        dx_q, dx_d, dy_q, dy_d, ystep_q, ystep_d;
   logic        steep_q, steep_d, start_err_q, start_err_d;
   logic        busy_q, busy_d, done_q, done_d;
   crd_t        dxs, dys, ady;

   assign dxs = x1_q - x0_q;
   assign dys = y1_q - y0_q;
   assign ady = dys[WIDTH-1] ? -dys : dys;
`ifdef LINE_SETUP_STEEP_EN
   crd_t adx;
   assign adx = dxs[WIDTH-1] ? -dxs : dxs;
`endif

   always_comb begin
      state_d     = state_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      ystep_d     = ystep_q;
      steep_d     = steep_q;
      busy_d      = busy_q;
      start_err_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: if (req) begin
            x0_d    = crd_t'(x0_in);
            y0_d    = crd_t'(y0_in);
            x1_d    = crd_t'(x1_in);
            y1_d    = crd_t'(y1_in);
            busy_d  = 1'b1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
`ifdef LINE_SETUP_STEEP_EN
            steep_d = ady > adx;
`else
            steep_d = 1'b0;
`endif
            state_d = S_STEEP;
         end
         S_STEEP: begin
`ifdef LINE_SETUP_STEEP_EN
            if (steep_q) begin
               x0_d = y0_q;  y0_d = x0_q;
               x1_d = y1_q;  y1_d = x1_q;
            end
`endif
            state_d = S_ORDER;
         end
         S_ORDER: begin
            if (x0_q > x1_q) begin
               x0_d = x1_q;  y0_d = y1_q;
               x1_d = x0_q;  y1_d = y0_q;
            end
            state_d = S_CALC;
         end
         S_CALC: begin
            dx_d        = dxs;
            dy_d        = ady;
            ystep_d     = (y0_q > y1_q) ? crd_t'(YSTEP_NEG) : crd_t'(YSTEP_POS);
            start_err_d = 1'b1;
            state_d     = S_START;
         end
         S_START: state_d = S_RUN;
         S_RUN: if (en_counter && last_count) begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x0_q        <= '0;
         y0_q        <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         ystep_q     <= '0;
         steep_q     <= 1'b0;
         start_err_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         ystep_q     <= ystep_d;
         steep_q     <= steep_d;
         start_err_q <= start_err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Counter is loaded while in CALC so xcount already shows x0 during START.
   x_counter #(.WIDTH(WIDTH)) u_xcnt (
      .clk        (clk),
      .rst        (rst),
      .load       (state_q == S_CALC),
      .run        (state_q == S_RUN),
      .en         (en_counter),
      .load_val   (x0_q),
      .x_end      (x1_q),
      .xcount     (xcount),
      .last_count (last_count)
   );

   assign x0        = x0_q;
   assign y0        = y0_q;
   assign deltax    = dx_q;
   assign deltay    = dy_q;
   assign ystep     = ystep_q;
   assign steep     = steep_q;
   assign start_err = start_err_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_line_setup.sv
// Directed bench for line_setup: setup results, latency, counter walk,
// degenerate/toggled lines and mid-line reset. Honours LINE_SETUP_STEEP_EN.
module tb_line_setup;
   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] x0_in = '0, y0_in = '0, x1_in = '0, y1_in = '0;
   logic         req = 1'b0, en_counter = 1'b0;
   logic [W-1:0] x0, y0, deltax, deltay, ystep, xcount;
   logic         start_err, last_count, steep, busy, done;

   int errors = 0;
   int checks = 0;

   line_setup #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
      .req(req), .en_counter(en_counter),
      .x0(x0), .y0(y0), .deltax(deltax), .deltay(deltay), .ystep(ystep),
      .xcount(xcount), .start_err(start_err), .last_count(last_count),
      .steep(steep), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Issue a one-cycle req and check latency up to the START cycle.
   task automatic launch(input int ax, input int ay, input int bx, input int by,
                         input int exp_x0);
      @(negedge clk);
      x0_in = W'(ax); y0_in = W'(ay); x1_in = W'(bx); y1_in = W'(by);
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (busy !== 1'b1 || start_err !== 1'b0) begin
         errors++;
         $display("FAIL launch_load: busy=%b start_err=%b, want busy=1 start_err=0", busy, start_err);
      end
      for (int k = 2; k <= 4; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (start_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL launch_early cycle N+%0d: start_err=%b busy=%b, want 0/1", k, start_err, busy);
         end
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (start_err !== 1'b1 || xcount !== W'(exp_x0)) begin
         errors++;
         $display("FAIL launch_start: start_err=%b xcount=%0d, want 1/%0d", start_err, xcount, exp_x0);
      end
   endtask

   // From the START cycle, walk RUN and check xcount/last_count then done.
   task automatic do_run(input int xs, input int xe, input bit toggle);
      int  ex = xs;
      bit  fin = 0;
      @(posedge clk);
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         checks++;
         if (xcount !== W'(ex) || last_count !== (ex == xe) || done !== 1'b0 || start_err !== 1'b0) begin
            errors++;
            $display("FAIL run_step %0d: xcount=%0d last=%b done=%b se=%b, want %0d/%b/0/0",
                     cyc, xcount, last_count, done, start_err, ex, (ex == xe));
         end
         en_counter = toggle ? cyc[0] : 1'b1;
         @(posedge clk);
         if (en_counter && ex == xe) begin fin = 1; break; end
         if (en_counter) ex++;
      end
      #1 en_counter = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL run_timeout: line did not reach x1=%0d", xe);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || last_count !== 1'b0) begin
         errors++;
         $display("FAIL run_done: done=%b busy=%b last=%b, want 1/1/0", done, busy, last_count);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL run_idle: done=%b busy=%b, want 0/0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({x0, y0, deltax, deltay, ystep, xcount} !== '0 ||
          {start_err, last_count, steep, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state: x0=%0d y0=%0d dx=%0d dy=%0d ys=%0d xc=%0d flags=%b, want all 0",
                  x0, y0, deltax, deltay, ystep, xcount, {start_err, last_count, steep, busy, done});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_setup(input string nm, input int ax, input int ay, input int bx, input int by,
                             input int ex0, input int ey0, input int ex1, input int edx, input int edy,
                             input int eys, input bit est, input bit toggle);
      launch(ax, ay, bx, by, ex0);
      checks++;
      if (x0 !== W'(ex0) || y0 !== W'(ey0) || deltax !== W'(edx) || deltay !== W'(edy) ||
          ystep !== W'(eys) || steep !== est) begin
         errors++;
         $display("FAIL setup_%s: x0=%0d y0=%0d dx=%0d dy=%0d ys=%h st=%b, want %0d/%0d/%0d/%0d/%h/%b",
                  nm, x0, y0, deltax, deltay, ystep, steep, ex0, ey0, edx, edy, W'(eys), est);
      end
      do_run(ex0, ex1, toggle);
      checks++;
      if (x0 !== W'(ex0) || deltax !== W'(edx) || deltay !== W'(edy) || steep !== est) begin
         errors++;
         $display("FAIL hold_%s: x0=%0d dx=%0d dy=%0d st=%b after line", nm, x0, deltax, deltay, steep);
      end
   endtask

   task automatic test_basic();
      test_setup("fwd", 10, 20, 50, 30, 10, 20, 50, 40, 10, 1, 1'b0, 1'b0);
   endtask

   task automatic test_order_swap();
      test_setup("rev", 50, 30, 10, 20, 10, 20, 50, 40, 10, 1, 1'b0, 1'b0);
   endtask

   task automatic test_steep();
`ifdef LINE_SETUP_STEEP_EN
      test_setup("steep", 5, 5, 8, 40, 5, 5, 40, 35, 3, 1, 1'b1, 1'b0);
`else
      test_setup("steep", 5, 5, 8, 40, 5, 5, 8, 3, 35, 1, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_neg_ystep();
      test_setup("negy", 0, 100, 60, 40, 0, 100, 60, 60, 60, -1, 1'b0, 1'b0);
   endtask

   task automatic test_degenerate();
      test_setup("point", 7, 7, 7, 7, 7, 7, 7, 0, 0, 1, 1'b0, 1'b1);
   endtask

   task automatic test_toggle();
      test_setup("toggle", 0, 0, 6, 3, 0, 0, 6, 6, 3, 1, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      launch(10, 0, 60, 0, 10);
      @(negedge clk);
      x0_in = W'(200); y0_in = W'(9); x1_in = W'(3); y1_in = W'(100);
      req = 1'b1; en_counter = 1'b1;
      for (int i = 0; i < 100 && xcount != W'(25); i++) @(negedge clk);
      checks++;
      if (xcount !== W'(25) || x0 !== W'(10) || deltax !== W'(50) || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_req_ignored: xcount=%0d x0=%0d dx=%0d busy=%b, want 25/10/50/1",
                  xcount, x0, deltax, busy);
      end
      rst = 1'b1; req = 1'b0; en_counter = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0 || xcount !== '0 || x0 !== '0 || deltax !== '0 || ystep !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b xc=%0d x0=%0d dx=%0d ys=%0d done=%b, want all 0",
                  busy, xcount, x0, deltax, ystep, done);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_abort cycle %0d: done=%b busy=%b", i, done, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_order_swap();
      test_steep();
      test_neg_ystep();
      test_degenerate();
      test_toggle();
      test_mid_reset();
      test_basic();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end
endmodule
